bin_to_bcd_seq: RTL



---
 rtl/bin_to_bcd_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative shift-add-3 (double-dabble) binary-to-BCD converter.
// One shift per clock, start/busy/done handshake, result = bin_in mod 10^DIGITS
// with a sticky overflow flag when the operand does not fit in DIGITS digits.
// Optional leading-zero blank mask is built only when the macro
// BCD_LEADING_ZERO_BLANK_EN is defined; otherwise blank is tied to zero.

module bin_to_bcd_seq #(
   parameter int BIN_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow,
   output logic [DIGITS-1:0]     blank
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int BCD_W = 4 * DIGITS;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t             state_q, state_d;
   logic [BIN_W-1:0]   binReg_q, binReg_d;
   logic [BCD_W-1:0]   scratch_q, scratch_d;
   logic               ovf_q, ovf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BCD_W-1:0]   bcdOut_q, bcdOut_d;
   logic               overflow_q, overflow_d;
   logic               done_q, done_d;

   logic [BCD_W-1:0]   adjusted;
   logic [BCD_W-1:0]   shifted;
   logic               carryOut;
   logic               finishing;

   // One double-dabble step: add 3 to every digit >= 5, then shift the next
   // operand bit in at the bottom. The bit leaving the top digit is a carry
   // worth 10^DIGITS, which is what marks the result as truncated.
   always_comb begin
      adjusted = scratch_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (scratch_q[4*k +: 4] >= 4'd5) begin
            adjusted[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
         end
      end
      carryOut = adjusted[BCD_W-1];
      shifted  = {adjusted[BCD_W-2:0], binReg_q[BIN_W-1]};
   end

   assign finishing = (state_q == SHIFT) && (cnt_q == LAST_CNT);

   // Next-state logic: IDLE waits for an accepted start, SHIFT runs exactly
   // BIN_W iterations and publishes the result on the last one.
   always_comb begin
      state_d    = state_q;
      binReg_d   = binReg_q;
      scratch_d  = scratch_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      bcdOut_d   = bcdOut_q;
      overflow_d = overflow_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               binReg_d  = bin_in;
               scratch_d = '0;
               ovf_d     = 1'b0;
               cnt_d     = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = shifted;
            binReg_d  = binReg_q << 1;
            ovf_d     = ovf_q | carryOut;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               bcdOut_d   = shifted;
               overflow_d = ovf_q | carryOut;
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over any conversion in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         binReg_q   <= '0;
         scratch_q  <= '0;
         ovf_q      <= 1'b0;
         cnt_q      <= '0;
         bcdOut_q   <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         binReg_q   <= binReg_d;
         scratch_q  <= scratch_d;
         ovf_q      <= ovf_d;
         cnt_q      <= cnt_d;
         bcdOut_q   <= bcdOut_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q == SHIFT);
   assign done     = done_q;
   assign bcd_out  = bcdOut_q;
   assign overflow = overflow_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d;
   logic [DIGITS-1:0] blankCalc;
   logic              higherZero;

   // A digit above the units is blanked when it and every digit above it are
   // zero; the units digit is never blanked so zero still shows "0".
   always_comb begin
      blankCalc  = '0;
      higherZero = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         higherZero   = higherZero & (shifted[4*k +: 4] == 4'd0);
         blankCalc[k] = higherZero;
      end
      blank_d = finishing ? blankCalc : blank_q;
   end

   // Blank mask is published together with bcd_out and held in between.
   always_ff @(posedge clk) begin
      if (reset) begin
         blank_q <= '0;
      end else begin
         blank_q <= blank_d;
      end
   end

   assign blank = blank_q;
`else
   assign blank = '0;
`endif

endmodule
